// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// master drives operands and out_ready; slave is the multiplier.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag, flags
  );

  modport slave (
    input  in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag, flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier, RNE rounding,
// flush-to-zero on subnormal inputs and outputs, global stall.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  fp_mul_pipe_if.slave io
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic             sgn;
    logic             nan;
    logic             inv;
    logic             inf;
    logic             zero;
    logic [XW-1:0]    exp;
    logic [TAG_W-1:0] tag;
  } cls_t;

  logic stall;
  logic adv;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             za, zb, ia, ib, na, nb, sna, snb, iz;

  cls_t           cls1_d, cls1_q, cls2_q;
  logic [MAN_W:0] ma1_d, mb1_d, ma1_q, mb1_q;
  logic           v1_q, v2_q, v3_q;
  logic [PW-1:0]  p2_d, p2_q;

  logic             ovf;
  logic [MAN_W-1:0] mant;
  logic             guard, sticky, up;
  logic [MAN_W:0]   mr;
  logic [XW-1:0]    e3;
  logic [W-1:0]     out_d, out_q;
  logic [3:0]       flags_d, flags_q;
  logic [TAG_W-1:0] tag_q;

  assign stall        = v3_q && !io.out_ready;
  assign adv          = !stall;
  assign io.in_ready  = adv;
  assign io.out_valid = v3_q;
  assign io.out       = out_q;
  assign io.out_tag   = tag_q;
  assign io.flags     = flags_q;

  assign {sa, ea, fa} = io.a;
  assign {sb, eb, fb} = io.b;

  // S1: classify operands and form the biased exponent sum
  always_comb begin
    za  = (ea == '0);
    zb  = (eb == '0);
    ia  = (&ea) && (fa == '0);
    ib  = (&eb) && (fb == '0);
    na  = (&ea) && (fa != '0);
    nb  = (&eb) && (fb != '0);
    sna = na && !fa[MAN_W-1];
    snb = nb && !fb[MAN_W-1];
    iz  = (ia && zb) || (za && ib);
    cls1_d      = '0;
    cls1_d.sgn  = sa ^ sb;
    cls1_d.nan  = na || nb || iz;
    cls1_d.inv  = sna || snb || iz;
    cls1_d.inf  = ia || ib;
    cls1_d.zero = za || zb;
    cls1_d.exp  = XW'(ea) + XW'(eb) - BIAS;
    cls1_d.tag  = io.in_tag;
    ma1_d = {1'b1, fa};
    mb1_d = {1'b1, fb};
  end

  // S1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      cls1_q <= '0;
      ma1_q  <= '0;
      mb1_q  <= '0;
    end else if (adv) begin
      v1_q   <= io.in_valid;
      cls1_q <= cls1_d;
      ma1_q  <= ma1_d;
      mb1_q  <= mb1_d;
    end
  end

  // S2: full-width significand product
  always_comb begin
    p2_d = PW'(ma1_q) * PW'(mb1_q);
  end

  // S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      cls2_q <= '0;
      p2_q   <= '0;
    end else if (adv) begin
      v2_q   <= v1_q;
      cls2_q <= cls1_q;
      p2_q   <= p2_d;
    end
  end

  // S3: normalise, round to nearest even, then pack by priority
  always_comb begin
    ovf    = p2_q[PW-1];
    mant   = ovf ? p2_q[PW-2 -: MAN_W] : p2_q[PW-3 -: MAN_W];
    guard  = ovf ? p2_q[MAN_W] : p2_q[MAN_W-1];
    sticky = ovf ? (|p2_q[MAN_W-1:0]) : (|p2_q[MAN_W-2:0]);
    up     = guard && (sticky || mant[0]);
    mr     = {1'b0, mant} + (MAN_W+1)'(up);
    e3     = cls2_q.exp + XW'(ovf) + XW'(mr[MAN_W]);
    out_d   = '0;
    flags_d = '0;
    if (cls2_q.nan) begin
      out_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d = {cls2_q.inv, 3'b000};
    end else if (cls2_q.inf) begin
      out_d = {cls2_q.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls2_q.zero) begin
      out_d = {cls2_q.sgn, {(W-1){1'b0}}};
    end else if (!e3[XW-1] && (e3 >= EMAX)) begin
      out_d   = {cls2_q.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (e3[XW-1] || (e3 == '0)) begin
      out_d   = {cls2_q.sgn, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else begin
      out_d   = {cls2_q.sgn, e3[EXP_W-1:0], mr[MAN_W-1:0]};
      flags_d = {3'b000, guard || sticky};
    end
  end

  // S3 register, drives the result port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q    <= 1'b0;
      out_q   <= '0;
      flags_q <= '0;
      tag_q   <= '0;
    end else if (adv) begin
      v3_q    <= v2_q;
      out_q   <= out_d;
      flags_q <= flags_d;
      tag_q   <= cls2_q.tag;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Randomised scoreboard bench for fp_mul_pipe in binary32 and
// half-precision builds, with directed special-value cases.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) i32 ();
  fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) i16 ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .io(i32)
  );
  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u16 (
    .clk(clk), .rst_n(rst_n), .io(i16)
  );

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic [3:0]  t;
  } exp_t;

  exp_t        q32[$];
  exp_t        q16[$];
  int          errors = 0;
  int          checks = 0;
  bit          stp[2];
  logic [40:0] held[2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Reference product from exact integer arithmetic
  function automatic void model(input int E, input int M,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] r,
                                output logic [3:0] f);
    longint unsigned fa, fb, p, q, rem, half, mmask, sgn, inf_v;
    int ea, eb, emax, bias, n, drop, e;
    bit za, zb, ia, ib, na, nb, sna, snb, iz;
    emax  = (1 << E) - 1;
    bias  = (1 << (E - 1)) - 1;
    mmask = (64'd1 << M) - 1;
    fa = a & mmask;
    fb = b & mmask;
    ea = int'((a >> M) & emax);
    eb = int'((b >> M) & emax);
    sgn   = (((a ^ b) >> (E + M)) & 1) << (E + M);
    inf_v = sgn | (longint'(emax) << M);
    za  = ea == 0;
    zb  = eb == 0;
    ia  = ea == emax && fa == 0;
    ib  = eb == emax && fb == 0;
    na  = ea == emax && fa != 0;
    nb  = eb == emax && fb != 0;
    sna = na && ((fa >> (M - 1)) & 1) == 0;
    snb = nb && ((fb >> (M - 1)) & 1) == 0;
    iz  = (ia && zb) || (za && ib);
    f = 4'b0;
    if (na || nb || iz) begin
      r = 32'((longint'(emax) << M) | (64'd1 << (M - 1)));
      f[3] = sna || snb || iz;
      return;
    end
    if (ia || ib) begin
      r = 32'(inf_v);
      return;
    end
    if (za || zb) begin
      r = 32'(sgn);
      return;
    end
    p = ((64'd1 << M) | fa) * ((64'd1 << M) | fb);
    n = 0;
    for (int i = 0; i < 64; i++)
      if (((p >> i) & 1) != 0) n = i;
    drop = n - M;
    q    = p >> drop;
    rem  = p & ((64'd1 << drop) - 1);
    half = 64'd1 << (drop - 1);
    if (rem > half || (rem == half && q[0])) q++;
    e = ea + eb - bias + (n - 2 * M);
    if ((q >> (M + 1)) != 0) begin
      q = q >> 1;
      e++;
    end
    if (e >= emax) begin
      r = 32'(inf_v);
      f = 4'b0101;
    end else if (e <= 0) begin
      r = 32'(sgn);
      f = 4'b0011;
    end else begin
      r = 32'(sgn | (longint'(e) << M) | (q & mmask));
      f[0] = rem != 0;
    end
  endfunction

  function automatic logic [31:0] rop(input int E, input int M);
    longint unsigned fr, s;
    int e, emax, bias;
    emax = (1 << E) - 1;
    bias = (1 << (E - 1)) - 1;
    case ($urandom % 8)
      0: e = 0;
      1: e = emax;
      2: e = $urandom_range(emax, 0);
      3: e = $urandom_range(emax - 1, emax - 3);
      4: e = $urandom_range(3, 1);
      default: e = $urandom_range(bias + 3, bias - 3);
    endcase
    fr = {$urandom, $urandom};
    fr = fr & ((64'd1 << M) - 1);
    if ($urandom % 4 == 0) fr = 0;
    s = $urandom % 2;
    return 32'((s << (E + M)) | (longint'(e) << M) | fr);
  endfunction

  task automatic mon(input bit h, input logic ir, input logic iv,
                     input logic ov, input logic ordy,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] o, input logic [3:0] it,
                     input logic [3:0] ot, input logic [3:0] fl);
    exp_t        e;
    logic [40:0] now;
    chk(h ? "in_ready16" : "in_ready32", ir, !(ov && !ordy));
    now = {ov, o, ot, fl};
    if (stp[h]) chk(h ? "hold16" : "hold32", now, held[h]);
    if (iv && ir) begin
      model(h ? 5 : 8, h ? 10 : 23, a, b, e.r, e.f);
      e.t = it;
      if (h) q16.push_back(e);
      else q32.push_back(e);
    end
    if (ov && ordy) begin
      if ((h ? q16.size() : q32.size()) == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious%0d: got %h expected none",
                 h ? 16 : 32, o);
      end else begin
        e = h ? q16.pop_front() : q32.pop_front();
        chk(h ? "out16" : "out32", o, e.r);
        chk(h ? "flags16" : "flags32", fl, e.f);
        chk(h ? "tag16" : "tag32", ot, e.t);
      end
    end
    stp[h]  = ov && !ordy;
    held[h] = now;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, i32.in_ready, i32.in_valid, i32.out_valid, i32.out_ready,
          i32.a, i32.b, i32.out, i32.in_tag, i32.out_tag, i32.flags);
      mon(1, i16.in_ready, i16.in_valid, i16.out_valid, i16.out_ready,
          {16'h0, i16.a}, {16'h0, i16.b}, {16'h0, i16.out},
          i16.in_tag, i16.out_tag, i16.flags);
    end else begin
      stp[0] = 1'b0;
      stp[1] = 1'b0;
    end
  end

  task automatic send(input bit h, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] t);
    bit ok;
    if (h) begin
      i16.a = a[15:0];
      i16.b = b[15:0];
      i16.in_tag = t;
      i16.in_valid = 1'b1;
    end else begin
      i32.a = a;
      i32.b = b;
      i32.in_tag = t;
      i32.in_valid = 1'b1;
    end
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (h ? i16.in_ready : i32.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected accept");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit h);
    if (h) i16.in_valid = 1'b0;
    else i32.in_valid = 1'b0;
  endtask

  task automatic drain();
    i32.out_ready = 1'b1;
    i16.out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (q32.size() == 0 && q16.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_left", q32.size() + q16.size(), 0);
  endtask

  task automatic run_rand(input bit h, input int cnt, input bit gaps);
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < cnt; i++) begin
          send(h, rop(h ? 5 : 8, h ? 10 : 23),
               rop(h ? 5 : 8, h ? 10 : 23), 4'(i));
          if (gaps && $urandom % 3 == 0) begin
            idle(h);
            @(posedge clk);
            #1;
          end
        end
        idle(h);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          if (h) i16.out_ready = 1'($urandom % 2);
          else i32.out_ready = 1'($urandom % 2);
        end
      end
    join
    drain();
  endtask

  localparam logic [31:0] DA[8] = '{
    32'h3F800001, 32'h3F800001, 32'h7F800000, 32'hFF800000,
    32'h00000001, 32'h7F000000, 32'h00800000, 32'h7FA00000};
  localparam logic [31:0] DB[8] = '{
    32'h3F800001, 32'h3FC00000, 32'h00000000, 32'h40000000,
    32'h7F000000, 32'h40000000, 32'h3F000000, 32'h3F800000};
  localparam logic [31:0] HA[3] = '{32'h3E00, 32'h3C01, 32'h3C01};
  localparam logic [31:0] HB[3] = '{32'h4000, 32'h3C01, 32'h3E00};

  logic [31:0] r;
  logic [3:0]  f;
  int          lat;
  int          seen;

  initial begin
    i32.in_valid = 1'b0;
    i32.a = '0;
    i32.b = '0;
    i32.in_tag = '0;
    i32.out_ready = 1'b0;
    i16.in_valid = 1'b0;
    i16.a = '0;
    i16.b = '0;
    i16.in_tag = '0;
    i16.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", i32.in_ready, 1'b1);
    chk("rst_out_valid", i32.out_valid, 1'b0);
    chk("rst_out", i32.out, 32'h0);
    chk("rst_out_tag", i32.out_tag, 4'h0);
    chk("rst_flags", i32.flags, 4'h0);
    chk("rst_out_valid16", i16.out_valid, 1'b0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    model(8, 23, 32'h3FC00000, 32'h40000000, r, f);
    chk("pin_basic", {r, f}, {32'h40400000, 4'h0});
    model(8, 23, 32'h3F800001, 32'h3F800001, r, f);
    chk("pin_round", {r, f}, {32'h3F800002, 4'h1});
    model(8, 23, 32'h3F800001, 32'h3FC00000, r, f);
    chk("pin_tie", {r, f}, {32'h3FC00002, 4'h1});
    model(8, 23, 32'h7F800000, 32'h00000000, r, f);
    chk("pin_infzero", {r, f}, {32'h7FC00000, 4'h8});
    model(8, 23, 32'hFF800000, 32'h40000000, r, f);
    chk("pin_neginf", {r, f}, {32'hFF800000, 4'h0});
    model(8, 23, 32'h00000001, 32'h7F000000, r, f);
    chk("pin_subn", {r, f}, {32'h00000000, 4'h0});
    model(8, 23, 32'h7F000000, 32'h40000000, r, f);
    chk("pin_ovf", {r, f}, {32'h7F800000, 4'h5});
    model(8, 23, 32'h00800000, 32'h3F000000, r, f);
    chk("pin_unf", {r, f}, {32'h00000000, 4'h3});
    model(5, 10, 32'h3E00, 32'h4000, r, f);
    chk("pin_half", {r, f}, {32'h4200, 4'h0});
    model(5, 10, 32'h3C01, 32'h3E00, r, f);
    chk("pin_half_tie", {r, f}, {32'h3E02, 4'h1});

    i32.out_ready = 1'b1;
    send(0, 32'h3FC00000, 32'h40000000, 4'h5);
    idle(0);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (i32.out_valid) break;
    end
    chk("latency", lat, 3);
    chk("basic_out", i32.out, 32'h40400000);
    chk("basic_tag", i32.out_tag, 4'h5);
    drain();

    for (int i = 0; i < 8; i++) send(0, DA[i], DB[i], 4'(i));
    idle(0);
    drain();
    for (int i = 0; i < 3; i++) send(1, HA[i], HB[i], 4'(i + 8));
    idle(1);
    drain();

    run_rand(0, 8, 1'b0);
    run_rand(0, 150, 1'b1);
    run_rand(1, 80, 1'b1);

    i32.out_ready = 1'b1;
    send(0, rop(8, 23), rop(8, 23), 4'hA);
    send(0, rop(8, 23), rop(8, 23), 4'hB);
    send(0, rop(8, 23), rop(8, 23), 4'hC);
    idle(0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", i32.out_valid, 1'b0);
    chk("midrst_in_ready", i32.in_ready, 1'b1);
    q32.delete();
    q16.delete();
    #20 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (i32.out_valid) seen++;
    end
    chk("post_rst_quiet", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
